// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline types: handshake FSM states and the EX/MEM and MEM/WB
// register payloads, reused by the hazard unit and the write-back stage.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [XLEN-1:0]   branch_target;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] write_register;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   alu_result;
    logic [REG_AW-1:0] write_register;
  } memwb_t;

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// Data-memory req/ack sequencer: RUN/WAIT FSM, wait counter, stall and timeout.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   access_c      an aligned memory op sits in the EX/MEM register
//   dmem_ack      memory completes the access this cycle
//   req_c         request to memory (combinational)
//   stall_c       access outstanding and not finishing this cycle
//   timeout_c     last permitted request cycle passed without an ack
module dmem_handshake
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic access_c,
  input  logic dmem_ack,
  output logic req_c,
  output logic stall_c,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  hs_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is held while the op stays in EX/MEM; the counter numbers WAIT
  // cycles from 1, so RUN plus TIMEOUT-1 WAIT cycles gives TIMEOUT requests.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    req_c     = access_c;
    timeout_c = (state_q == WAIT) & req_c & ~dmem_ack &
                (cnt_q == CNT_W'(TIMEOUT - 1));
    stall_c   = req_c & ~dmem_ack & ~timeout_c;
    case (state_q)
      RUN:     if (stall_c)  state_d = WAIT;
      WAIT:    if (!stall_c) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (state_d == WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory stage: EX/MEM register, branch resolution, data-memory access
// over req/ack, registered MEM/WB bundle and error pulses.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_*                         execution-stage results and control bits
//   pc_src, branch_target        taken-branch redirect to fetch
//   stall                        freeze IF/ID/EX and EX/MEM
//   dmem_req/we/addr/wdata       memory request, dmem_ack/dmem_rdata response
//   wb_*                         registered MEM/WB bundle
//   misaligned, bus_error        one-cycle pulses with an aborted op's retirement
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic [XLEN-1:0]   ex_branch_target,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_write_register,
  output logic              pc_src,
  output logic [XLEN-1:0]   branch_target,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [XLEN-1:0]   wb_read_data,
  output logic [XLEN-1:0]   wb_alu_result,
  output logic [REG_AW-1:0] wb_write_register,
  output logic              misaligned,
  output logic              bus_error
);

  exmem_t xm_q, xm_d;
  memwb_t wb_q, wb_d;
  logic   misaligned_q, misaligned_d;
  logic   bus_error_q, bus_error_d;

  logic mem_op_c, aligned_c, is_store_c, timeout_c;

  dmem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk       (clk),
    .rst       (rst),
    .access_c  (mem_op_c & aligned_c),
    .dmem_ack  (dmem_ack),
    .req_c     (dmem_req),
    .stall_c   (stall),
    .timeout_c (timeout_c)
  );

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xm_q         <= '0;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      xm_q         <= xm_d;
      wb_q         <= wb_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // Branch resolution, memory drive and next-register values
  always_comb begin
    mem_op_c      = xm_q.valid & (xm_q.mem_read | xm_q.mem_write);
    aligned_c     = (xm_q.alu_result[1:0] == 2'b00);
    // Read wins when both read and write are set
    is_store_c    = xm_q.mem_write & ~xm_q.mem_read;

    pc_src        = xm_q.valid & xm_q.branch & xm_q.zero;
    branch_target = xm_q.branch_target;
    dmem_we       = dmem_req & is_store_c;
    dmem_addr     = xm_q.alu_result;
    dmem_wdata    = xm_q.store_data;

    xm_d = xm_q;
    if (!stall) begin
      // A taken branch squashes the wrong-path instruction now in EX
      xm_d.valid          = ex_valid & ~pc_src;
      xm_d.reg_write      = ex_reg_write;
      xm_d.mem_to_reg     = ex_mem_to_reg;
      xm_d.mem_read       = ex_mem_read;
      xm_d.mem_write      = ex_mem_write;
      xm_d.branch         = ex_branch;
      xm_d.zero           = ex_zero;
      xm_d.branch_target  = ex_branch_target;
      xm_d.alu_result     = ex_alu_result;
      xm_d.store_data     = ex_store_data;
      xm_d.write_register = ex_write_register;
    end

    wb_d         = '0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    if (!stall) begin
      wb_d.valid          = xm_q.valid;
      wb_d.reg_write      = xm_q.valid & xm_q.reg_write & ~is_store_c;
      wb_d.mem_to_reg     = xm_q.valid & xm_q.mem_to_reg;
      wb_d.alu_result     = xm_q.alu_result;
      wb_d.write_register = xm_q.write_register;
      if (dmem_req & dmem_ack & xm_q.mem_read) wb_d.read_data = dmem_rdata;
      // Aborted accesses still retire but never write the register file
      if (mem_op_c & ~aligned_c) begin
        wb_d.reg_write = 1'b0;
        misaligned_d   = 1'b1;
      end
      if (timeout_c) begin
        wb_d.reg_write = 1'b0;
        bus_error_d    = 1'b1;
      end
    end
  end

  assign wb_valid          = wb_q.valid;
  assign wb_reg_write      = wb_q.reg_write;
  assign wb_mem_to_reg     = wb_q.mem_to_reg;
  assign wb_read_data      = wb_q.read_data;
  assign wb_alu_result     = wb_q.alu_result;
  assign wb_write_register = wb_q.write_register;
  assign misaligned        = misaligned_q;
  assign bus_error         = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected retirements and
// point checks into queues; a monitor samples each cycle and compares.
module tb_mem_stage;

  logic        clk, rst;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_zero;
  logic [31:0] ex_branch_target, ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_register;
  logic        pc_src, stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, misaligned, bus_error;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_register;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_branch_target(ex_branch_target), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_register(ex_write_register),
    .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_write_register(wb_write_register), .misaligned(misaligned), .bus_error(bus_error)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        mis;
    logic        berr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t chk_q[$];

  int checks = 0;
  int errors = 0;

  int stall_cnt = 0, req_cnt = 0, pc_cnt = 0, mis_cnt = 0, berr_cnt = 0;
  logic [31:0] last_tgt = 0, last_addr = 0, last_wdata = 0;
  logic        last_we = 0;

  int          ack_delay = 0;      // request cycles without ack before ack; -1 never
  logic [31:0] rdata_val = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void expect_eq(string name, logic [31:0] act, logic [31:0] exp);
    dchk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  function automatic void push_exp(logic rw, logic m2r, logic [31:0] rd, logic [31:0] alu,
                                   logic [4:0] wr, logic mis, logic berr);
    exp_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.wr = wr; e.mis = mis; e.berr = berr;
    exp_q.push_back(e);
  endfunction

  // Memory model: acks after ack_delay un-acked request cycles
  initial begin
    int req_run;
    req_run    = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      #1;
      if (dmem_req) begin
        dmem_ack   = (ack_delay >= 0) && (req_run == ack_delay);
        dmem_rdata = dmem_ack ? rdata_val : 32'hBAD0BAD0;
        req_run    = dmem_ack ? 0 : req_run + 1;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hBAD0BAD0;
        req_run    = 0;
      end
    end
  end

  // Monitor: sole owner of the check counters
  initial begin
    dchk_t       c;
    exp_t        e;
    logic        prev_pend;
    logic [31:0] prev_addr;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        chk(c.name, c.act, c.exp);
      end
      if (dmem_req && prev_pend) chk("addr_stable", dmem_addr, prev_addr);
      prev_pend = dmem_req & stall;
      prev_addr = dmem_addr;
      if (stall)    stall_cnt++;
      if (dmem_req) req_cnt++;
      if (pc_src) begin
        pc_cnt++;
        last_tgt = branch_target;
      end
      if (misaligned) mis_cnt++;
      if (bus_error)  berr_cnt++;
      if (dmem_req && dmem_ack) begin
        last_we    = dmem_we;
        last_addr  = dmem_addr;
        last_wdata = dmem_wdata;
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("wb_unexpected_retire", 32'(wb_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wb_reg_write",      32'(wb_reg_write),      32'(e.rw));
          chk("wb_mem_to_reg",     32'(wb_mem_to_reg),     32'(e.m2r));
          chk("wb_read_data",      wb_read_data,           e.rd);
          chk("wb_alu_result",     wb_alu_result,          e.alu);
          chk("wb_write_register", 32'(wb_write_register), 32'(e.wr));
          chk("misaligned",        32'(misaligned),        32'(e.mis));
          chk("bus_error",         32'(bus_error),         32'(e.berr));
        end
      end else if (misaligned || bus_error) begin
        chk("err_without_retire", 32'({misaligned, bus_error}), 32'd0);
      end
    end
  end

  task automatic clear_ex();
    ex_valid = 0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_branch = 0; ex_zero = 0; ex_branch_target = 0; ex_alu_result = 0; ex_store_data = 0;
    ex_write_register = 0;
  endtask

  // Present one instruction at a negedge; return at the negedge after EX/MEM takes it
  task automatic issue(input logic rw, input logic m2r, input logic mr, input logic mw,
                       input logic br, input logic z, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wr);
    bit done;
    done = 0;
    ex_valid = 1; ex_reg_write = rw; ex_mem_to_reg = m2r; ex_mem_read = mr;
    ex_mem_write = mw; ex_branch = br; ex_zero = z; ex_branch_target = tgt;
    ex_alu_result = alu; ex_store_data = sd; ex_write_register = wr;
    for (int i = 0; i < 100 && !done; i++) begin
      #4;
      done = !stall;
      @(negedge clk);
    end
    if (!done) expect_eq("issue_accept_timeout", 32'(stall), 32'd0);
    clear_ex();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    if (!done) expect_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int s0, r0, p0, m0, b0;
    rst = 1'b1;
    clear_ex();
    repeat (2) @(negedge clk);
    expect_eq("rst_pc_src",        32'(pc_src),        0);
    expect_eq("rst_stall",         32'(stall),         0);
    expect_eq("rst_dmem_req",      32'(dmem_req),      0);
    expect_eq("rst_dmem_we",       32'(dmem_we),       0);
    expect_eq("rst_dmem_addr",     dmem_addr,          0);
    expect_eq("rst_dmem_wdata",    dmem_wdata,         0);
    expect_eq("rst_branch_target", branch_target,      0);
    expect_eq("rst_wb_valid",      32'(wb_valid),      0);
    expect_eq("rst_misaligned",    32'(misaligned),    0);
    expect_eq("rst_bus_error",     32'(bus_error),     0);
    rst = 1'b0;
    @(negedge clk);

    // ALU op: two-edge latency, no stall
    s0 = stall_cnt;
    push_exp(1, 0, 0, 32'h1234, 5, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 5);
    expect_eq("alu_lat_edge1_valid", 32'(wb_valid), 0);
    @(negedge clk);
    expect_eq("alu_lat_edge2_valid", 32'(wb_valid), 1);
    expect_eq("alu_lat_edge2_data",  wb_alu_result, 32'h1234);
    drain();
    expect_eq("alu_stall_cycles", 32'(stall_cnt - s0), 0);

    // LW at 0x40 acked after three wait cycles
    s0 = stall_cnt; r0 = req_cnt;
    ack_delay = 3; rdata_val = 32'hDEADBEEF;
    push_exp(1, 1, 32'hDEADBEEF, 32'h40, 8, 0, 0);
    issue(1, 1, 1, 0, 0, 0, 0, 32'h40, 0, 8);
    drain();
    expect_eq("lw_stall_cycles", 32'(stall_cnt - s0), 3);
    expect_eq("lw_req_cycles",   32'(req_cnt - r0),   4);
    expect_eq("lw_addr",         last_addr,           32'h40);
    expect_eq("lw_we",           32'(last_we),        0);

    // Misaligned SW at 0x42: no request, misaligned pulse
    r0 = req_cnt; m0 = mis_cnt;
    push_exp(0, 0, 0, 32'h42, 0, 1, 0);
    issue(0, 0, 0, 1, 0, 0, 0, 32'h42, 32'h55, 0);
    drain();
    expect_eq("sw_mis_req_cycles",   32'(req_cnt - r0), 0);
    expect_eq("sw_mis_pulse_cycles", 32'(mis_cnt - m0), 1);

    // Aligned SW at 0x44 with zero-wait ack
    s0 = stall_cnt; r0 = req_cnt;
    ack_delay = 0;
    push_exp(0, 0, 0, 32'h44, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 0, 0, 32'h44, 32'h55, 0);
    drain();
    expect_eq("sw_req_cycles",   32'(req_cnt - r0),   1);
    expect_eq("sw_stall_cycles", 32'(stall_cnt - s0), 0);
    expect_eq("sw_we",           32'(last_we),        1);
    expect_eq("sw_wdata",        last_wdata,          32'h55);
    expect_eq("sw_addr",         last_addr,           32'h44);

    // Taken BEQ squashes the following instruction; the one after retires
    p0 = pc_cnt;
    push_exp(0, 0, 0, 32'h0, 0, 0, 0);
    push_exp(1, 0, 0, 32'h99, 10, 0, 0);
    issue(0, 0, 0, 0, 1, 1, 32'h100, 32'h0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 32'h77, 0, 9);
    issue(1, 0, 0, 0, 0, 0, 0, 32'h99, 0, 10);
    drain();
    expect_eq("beq_pc_src_cycles", 32'(pc_cnt - p0), 1);
    expect_eq("beq_target",        last_tgt,         32'h100);

    // LW never acked: 16 request cycles, bus error, then pipeline resumes
    s0 = stall_cnt; r0 = req_cnt; b0 = berr_cnt;
    ack_delay = -1; rdata_val = 32'h0BADF00D;
    push_exp(0, 1, 0, 32'h80, 11, 0, 1);
    push_exp(1, 0, 0, 32'hABC, 12, 0, 0);
    issue(1, 1, 1, 0, 0, 0, 0, 32'h80, 0, 11);
    issue(1, 0, 0, 0, 0, 0, 0, 32'hABC, 0, 12);
    drain();
    expect_eq("to_req_cycles",   32'(req_cnt - r0),   16);
    expect_eq("to_stall_cycles", 32'(stall_cnt - s0), 15);
    expect_eq("to_berr_pulses",  32'(berr_cnt - b0),  1);

    // Reset during the WAIT of a load
    ex_valid = 1; ex_reg_write = 1; ex_mem_to_reg = 1; ex_mem_read = 1;
    ex_alu_result = 32'h20; ex_write_register = 3;
    @(negedge clk);
    clear_ex();
    repeat (2) @(negedge clk);
    expect_eq("pre_rst_stall", 32'(stall), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    #2;
    expect_eq("post_rst_dmem_req",      32'(dmem_req),          0);
    expect_eq("post_rst_stall",         32'(stall),             0);
    expect_eq("post_rst_wb_valid",      32'(wb_valid),          0);
    expect_eq("post_rst_wb_reg_write",  32'(wb_reg_write),      0);
    expect_eq("post_rst_wb_mem_to_reg", 32'(wb_mem_to_reg),     0);
    expect_eq("post_rst_wb_read_data",  wb_read_data,           0);
    expect_eq("post_rst_wb_alu_result", wb_alu_result,          0);
    expect_eq("post_rst_wb_wr",         32'(wb_write_register), 0);
    @(negedge clk);
    #2;
    expect_eq("post_rst_no_req",        32'(dmem_req),          0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
